// File: rtl/buffer_pkg.sv
// Shared definitions for the frame-buffer access arbiter: FSM encoding,
// default timeout and the requester role convention.
package buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_BUSY    = 2'd2,
      ST_RELEASE = 2'd3
   } arb_state_t;

   localparam int DEFAULT_TIMEOUT = 8;

   // Role bit in WRITER_MASK: 1 marks a writer, 0 a reader.
   localparam logic ROLE_WRITER = 1'b1;
   localparam logic ROLE_READER = 1'b0;

   // A writer may only fill an empty buffer; a reader may only drain a full one.
   function automatic logic is_eligible(input logic rq, input logic role, input logic full);
      return rq && ((role == ROLE_WRITER) ? !full : full);
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: first eligible index strictly after
// the pointer, searching upward with wrap-around.
module rr_priority_select #(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] i_eligible,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [ID_W-1:0]    o_sel,
   output logic               o_any_valid
);

   // Scanning from the farthest candidate back to the nearest lets the last
   // hit win, so the closest index after the pointer is chosen without a break.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      o_sel = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         int idx;
         idx = int'(i_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (i_eligible[idx]) o_sel = ID_W'(idx);
      end
   end

   assign o_any_valid = |i_eligible;

endmodule

// File: rtl/buffer_access_arbiter.sv
// Single-port frame-buffer arbiter: round-robin grant among writer/reader
// requesters gated by a one-frame occupancy flag, with grant timeout.
module buffer_access_arbiter
   import buffer_pkg::*;
#(
   parameter int                 NUM_REQ     = 3,
   parameter logic [NUM_REQ-1:0] WRITER_MASK = 3'b001,
   parameter int                 TIMEOUT     = DEFAULT_TIMEOUT,
   parameter int                 ID_W        = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] i_rq,
   input  logic [NUM_REQ-1:0] i_busy,
   output logic [NUM_REQ-1:0] o_ack,
   output logic               o_grant_valid,
   output logic [ID_W-1:0]    o_grant_id,
   output logic               o_buf_full,
   output logic               o_timeout_err
);

   localparam int              TMR_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   arb_state_t         r_state;
   logic [NUM_REQ-1:0] r_ack;
   logic               r_grant_valid;
   logic [ID_W-1:0]    r_grant_id;
   logic [ID_W-1:0]    r_ptr;
   logic [TMR_W-1:0]   r_timer;
   logic               r_buf_full;
   logic               r_timeout_err;

   logic [NUM_REQ-1:0] w_eligible;
   logic [ID_W-1:0]    w_sel;
   logic               w_any;
   logic               w_busy_gnt;

   always_comb begin
      w_eligible = '0;
      for (int i = 0; i < NUM_REQ; i++)
         w_eligible[i] = is_eligible(i_rq[i], WRITER_MASK[i], r_buf_full);
   end

   rr_priority_select #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_select (
      .i_eligible  (w_eligible),
      .i_ptr       (r_ptr),
      .o_sel       (w_sel),
      .o_any_valid (w_any)
   );

   // Only the granted requester's busy line is ever observed.
   assign w_busy_gnt = i_busy[r_grant_id];

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_ack         <= '0;
         r_grant_valid <= 1'b0;
         r_grant_id    <= '0;
         r_ptr         <= ID_W'(NUM_REQ - 1);
         r_timer       <= '0;
         r_buf_full    <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_ack         <= NUM_REQ'(1) << w_sel;
                  r_grant_valid <= 1'b1;
                  r_grant_id    <= w_sel;
                  r_ptr         <= w_sel;
                  r_timer       <= '0;
                  r_state       <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (w_busy_gnt) begin
                  r_state <= ST_BUSY;
               end else if (r_timer == TMR_LAST) begin
                  r_ack         <= '0;
                  r_grant_valid <= 1'b0;
                  r_timeout_err <= 1'b1;
                  r_state       <= ST_RELEASE;
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end
            ST_BUSY: begin
               if (!w_busy_gnt) begin
                  r_ack         <= '0;
                  r_grant_valid <= 1'b0;
                  r_buf_full    <= (WRITER_MASK[r_grant_id] == ROLE_WRITER);
                  r_state       <= ST_RELEASE;
               end
            end
            // One dead cycle guarantees the requester sees ack low before any re-grant.
            ST_RELEASE: r_state <= ST_IDLE;
            default:    r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_ack         = r_ack;
   assign o_grant_valid = r_grant_valid;
   assign o_grant_id    = r_grant_id;
   assign o_buf_full    = r_buf_full;
   assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_buffer_access_arbiter.sv
// Self-checking bench for buffer_access_arbiter: directed scenarios plus
// randomized traffic, all compared cycle by cycle against a behavioural model.
module tb_buffer_access_arbiter;

   localparam int         N     = 3;
   localparam int         ID_W  = 2;
   localparam int         TMO   = 8;
   localparam logic [2:0] WMASK = 3'b001;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    rq;
   logic [N-1:0]    busy;
   logic [N-1:0]    o_ack;
   logic            o_grant_valid;
   logic [ID_W-1:0] o_grant_id;
   logic            o_buf_full;
   logic            o_timeout_err;

   always #5 clk = ~clk;

   buffer_access_arbiter #(
      .NUM_REQ     (N),
      .WRITER_MASK (WMASK),
      .TIMEOUT     (TMO),
      .ID_W        (ID_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_rq          (rq),
      .i_busy        (busy),
      .o_ack         (o_ack),
      .o_grant_valid (o_grant_valid),
      .o_grant_id    (o_grant_id),
      .o_buf_full    (o_buf_full),
      .o_timeout_err (o_timeout_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model: who holds the buffer, whether it started its access,
   // how long it has waited, and whether we are in the post-release gap.
   int m_holder;
   int m_last;
   int m_gid;
   int m_age;
   bit m_active;
   bit m_cool;
   bit m_full;
   bit m_to;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic bit is_writer(input int i);
      logic [2:0] m;
      m = WMASK;
      return m[i];
   endfunction

   task automatic model_reset();
      m_holder = -1;
      m_last   = N - 1;
      m_gid    = 0;
      m_age    = 0;
      m_active = 0;
      m_cool   = 0;
      m_full   = 0;
      m_to     = 0;
   endtask

   task automatic model_step();
      m_to = 0;
      if (m_cool) begin
         m_cool = 0;
      end else if (m_holder < 0) begin
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (m_holder < 0 && rq[j] && (is_writer(j) ? !m_full : m_full)) begin
               m_holder = j;
               m_last   = j;
               m_gid    = j;
               m_age    = 0;
               m_active = 0;
            end
         end
      end else if (!m_active) begin
         if (busy[m_holder]) m_active = 1;
         else if (m_age == TMO - 1) begin
            m_holder = -1;
            m_to     = 1;
            m_cool   = 1;
         end else m_age++;
      end else if (!busy[m_holder]) begin
         m_full   = is_writer(m_holder);
         m_holder = -1;
         m_cool   = 1;
      end
   endtask

   task automatic compare_all();
      check("ack", o_ack, (m_holder >= 0) ? (32'd1 << m_holder) : 32'd0);
      check("grant_valid", o_grant_valid, (m_holder >= 0) ? 32'd1 : 32'd0);
      check("grant_id", o_grant_id, m_gid);
      check("buf_full", o_buf_full, m_full);
      check("timeout_err", o_timeout_err, m_to);
   endtask

   // One clock: advance model on the edge, compare on the falling edge.
   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic wait_ack(input int limit);
      bit ok;
      ok = 0;
      for (int c = 0; c < limit && !ok; c++) begin
         tick();
         if (o_ack != '0) ok = 1;
      end
      check("ack_wait", {31'd0, ok}, 32'd1);
   endtask

   // Granted requester holds busy for n cycles, then the arbiter returns to idle.
   task automatic serve(input int n);
      busy = o_ack;
      repeat (n) tick();
      busy = '0;
      repeat (2) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rq    = '0;
      busy  = '0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int hi;
      int pulses;
      int gap;

      reset = 1'b1;
      rq    = '0;
      busy  = '0;
      model_reset();
      #1;
      check("rst_ack", o_ack, 0);
      check("rst_gv", o_grant_valid, 0);
      check("rst_gid", o_grant_id, 0);
      check("rst_full", o_buf_full, 0);
      check("rst_to", o_timeout_err, 0);
      repeat (2) tick();
      reset = 1'b0;

      // Write then read
      rq = 3'b001;
      tick();
      check("wr_ack_latency", o_ack, 3'b001);
      rq   = '0;
      busy = 3'b001;
      repeat (5) tick();
      busy = '0;
      repeat (2) tick();
      check("wr_full", o_buf_full, 1);
      rq = 3'b010;
      wait_ack(4);
      check("rd_gid", o_grant_id, 1);
      rq = '0;
      serve(2);
      check("rd_empty", o_buf_full, 0);

      // Readers blocked on an empty buffer
      do_reset();
      rq = 3'b110;
      repeat (20) tick();
      check("blk_ack", o_ack, 0);
      check("blk_full", o_buf_full, 0);
      rq = '0;

      // Persistent requests from everyone: alternating write/read rotation
      rq = 3'b111;
      for (int op = 0; op < 8; op++) begin
         wait_ack(10);
         serve(1 + int'($urandom_range(0, 2)));
      end
      rq = '0;
      repeat (2) tick();

      // Timeout with busy never rising
      do_reset();
      rq = 3'b001;
      wait_ack(4);
      rq     = '0;
      hi     = 1;
      pulses = 0;
      repeat (12) begin
         tick();
         if (o_ack[0]) hi++;
         if (o_timeout_err) pulses++;
      end
      check("to_ack_cycles", hi, TMO);
      check("to_pulses", pulses, 1);
      check("to_full", o_buf_full, 0);

      // Asynchronous reset in the middle of a write
      rq = 3'b001;
      wait_ack(4);
      rq   = '0;
      busy = 3'b001;
      repeat (3) tick();
      #2 reset = 1'b1;
      #1;
      check("arst_ack", o_ack, 0);
      check("arst_gv", o_grant_valid, 0);
      check("arst_full", o_buf_full, 0);
      busy = '0;
      tick();
      reset = 1'b0;
      rq = 3'b001;
      wait_ack(4);
      check("arst_regrant", o_ack, 3'b001);
      rq = '0;
      serve(2);

      // Full buffer blocks the writer until a read completes
      rq = 3'b001;
      repeat (10) tick();
      check("full_blk_ack", o_ack, 0);
      rq = 3'b011;
      wait_ack(4);
      check("full_rd_gid", o_grant_id, 1);
      rq   = 3'b001;
      busy = 3'b010;
      repeat (2) tick();
      busy = '0;
      tick();
      gap = 0;
      for (int c = 0; c < 6 && !o_ack[0]; c++) begin
         tick();
         gap++;
      end
      check("full_wr_gap", gap, 2);
      rq = '0;
      serve(1);

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 3) == 0) rq = N'($urandom);
         busy = N'($urandom);
         tick();
      end
      rq   = '0;
      busy = '0;
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/buffer_access_arbiter.md
Name: buffer_access_arbiter

Overview:
- Arbitrates single-port access to one frame buffer among NUM_REQ requesters: writer and reader FSMs using the rq/ack/busy handshake.
- Grants one requester at a time, round-robin.
- Tracks buffer occupancy (one frame): readers get access only after a completed write; writers only after a completed read.
- Drives the buffer-port mux select for the datapath.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- WRITER_MASK, 3'b001, bit i = 1 means requester i is a writer, otherwise a reader.
- TIMEOUT, 8, cycles allowed between ack assertion and busy rise before the grant is revoked.
- ID_W, 2, width of grant_id; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- rq  in  NUM_REQ  per-requester access request (level).
- busy  in  NUM_REQ  per-requester "access in progress" (the requester's reading/writing output).
- ack  out  NUM_REQ  per-requester grant, one-hot or zero.
- grant_valid  out  1  high in GRANT and BUSY states.
- grant_id  out  ID_W  index of the current or last granted requester; buffer mux select.
- buf_full  out  1  buffer holds an unread frame.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset values: ack=0, grant_valid=0, grant_id=0, buf_full=0, timeout_err=0, state=IDLE, rr pointer=NUM_REQ-1, timer=0.
  - Reset asserted mid-operation aborts the grant immediately.
  - The occupancy flag is lost on reset.
- All outputs are registered.
- Eligibility, requester i: rq[i] && (WRITER_MASK[i] ? !buf_full : buf_full).
- FSM states:
  - IDLE:
    - If any requester is eligible, select the first eligible index searching from ptr+1 upward with wrap.
    - Then: ack[sel]<=1, grant_id<=sel, ptr<=sel, timer<=0, go GRANT.
    - Grant latency: 1 cycle from the first sampled eligible rq to ack high.
    - No eligible requester: stay in IDLE.
  - GRANT:
    - busy[grant_id]=1: go BUSY.
    - Otherwise timer increments.
    - timer==TIMEOUT-1 without busy: ack<=0, timeout_err<=1 (single cycle), go RELEASE; buf_full unchanged.
  - BUSY:
    - Hold ack high while busy[grant_id]=1.
    - On busy low: ack<=0; buf_full<=1 if the granted requester is a writer, else buf_full<=0; go RELEASE.
  - RELEASE:
    - grant_valid=0, ack=0.
    - Go IDLE after one cycle; this guarantees the requester observes ack low for at least 1 cycle before any re-grant.
- rq is ignored outside IDLE; the requester is expected to drop rq once it sees ack.
- rq or busy of non-granted requesters are ignored.
- Simultaneous eligible requests: round-robin order only. Writers and readers are never both eligible in the same cycle, by the buf_full rule.
- rq withdrawn before grant: no grant is issued; no state change.
- busy rising in the same cycle ack rises: sampled normally next cycle.
- Back-to-back operations: minimum of 4 cycles between successive ack rising edges (IDLE, GRANT, BUSY≥1, RELEASE).

Decomposition:
- Shared package (buffer_pkg):
  - FSM state encodings IDLE/GRANT/BUSY/RELEASE (2-bit).
  - Default TIMEOUT constant.
  - The requester role convention (1 = writer).
- Natural sub-module: rr_priority_select.
  - Combinational round-robin picker taking eligible vector and pointer, producing sel index and any_valid.
- FSM, timer and occupancy flag live in the top module.

Test Plan:
- Write-then-read:
  - rq=3'b001, busy[0] high 5 cycles, then low.
  - Required: ack=001 one cycle after rq; buf_full=1 after RELEASE.
  - Then rq=3'b010 is granted, with grant_id=1.
- Reader blocked when empty: after reset, rq=3'b110 held 20 cycles -> ack stays 000, buf_full=0.
- Round-robin:
  - buf_full=1, both readers requesting persistently, each read followed by a write.
  - Reader grant sequence: 1,2,1,2.
- Timeout:
  - rq[0]=1 and granted, busy never rises.
  - Required: ack[0] drops after 8 cycles in GRANT; timeout_err pulses exactly once; buf_full unchanged (0).
- Reset mid-BUSY:
  - Assert reset while a writer has busy high.
  - Required: ack=0, grant_valid=0, buf_full=0 the same cycle (asynchronous).
  - After release of reset, a writer rq is granted again.
- Full buffer blocks writer: buf_full=1, rq=3'b001 -> no grant until a reader completes; then the writer is granted 2 cycles after the read's RELEASE.
